gpr_bank: RTL

General-register storage bank for the PA-RISC datapath. It holds GR0..GR31, takes the single writeback port, and presents every register's current value in parallel to the downstream 32:1 read-port multiplexers, one per read port. It also keeps a per-register busy scoreboard that decode uses to detect read-after-write hazards. GR0 is architecturally hardwired to zero.

---
 rtl/gpr_pkg.sv | 16 +
 rtl/gpr_cell.sv | 22 ++
 rtl/gpr_bank.sv | 84 ++++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared sizes and helpers for the general-register bank.
// GR0 index and the flat read-bus slice offset live here.
package gpr_pkg;

    localparam int WIDTH  = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] GR0 = '0;

    // bit offset of register n inside the flat read bus
    function automatic int slot_off(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/gpr_cell.sv
// gpr_cell: one general register with load enable.
// Cleared asynchronously by rst.
module gpr_cell #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // load on enable, clear on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/gpr_bank.sv
// gpr_bank: GR0..GR31 storage, writeback port,
// busy scoreboard, hazard stall and write counter.
module gpr_bank
    import gpr_pkg::*;
#(
    parameter int WIDTH  = gpr_pkg::WIDTH,
    parameter int NREGS  = gpr_pkg::NREGS,
    parameter int ADDR_W = gpr_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       rw,
    input  logic [WIDTH-1:0]        pw,
    input  logic                    busy_set,
    input  logic [ADDR_W-1:0]       busy_rd,
    input  logic [ADDR_W-1:0]       ra,
    input  logic [ADDR_W-1:0]       rb,
    output logic [NREGS*WIDTH-1:0]  r_flat,
    output logic [NREGS-1:0]        busy_vec,
    output logic                    stall,
    output logic [15:0]             wr_count
);

    logic            wr_ok;
    logic [NREGS-1:0] busy;

    assign wr_ok = we && (rw != ADDR_W'(GR0));

    // GR0 reads as constant zero
    assign r_flat[WIDTH-1:0] = '0;

    for (genvar n = 1; n < NREGS; n++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(n);
        localparam int OFF = slot_off(n, WIDTH);

        logic ld;

        assign ld = we && (rw == IDX);

        gpr_cell #(
            .W (WIDTH)
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .ld  (ld),
            .d   (pw),
            .q   (r_flat[OFF +: WIDTH])
        );
    end

    // scoreboard: a new producer overrides a retiring write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREGS; i++) begin
                if (busy_set && busy_rd == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if (we && rw == ADDR_W'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy;

    // hazard on either source; GR0 bit is never set
    always_comb begin
        stall = busy[ra] | busy[rb];
    end

    // count accepted writes, holding at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wr_ok && wr_count != 16'hFFFF) begin
            wr_count <= wr_count + 16'd1;
        end
    end

endmodule
